bus_ram: RTL and testbench

//  Parametrised multi-channel system RAM for the SoC; generalises the single-port, fixed-width memory model.

---
 rtl/bus_ram_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/bus_ram.sv | 119 +++++++++++
 tb/tb_bus_ram.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ram_pkg.sv
// Shared constants and helpers for the multi-channel system RAM.
package bus_ram_pkg;

  localparam int BYTE_W = 8;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above rr_ptr wins,
// pointer moves past the winner on advance.
module rr_arbiter
  import bus_ram_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              req,
  input  logic                      advance,
  output logic [N-1:0]              grant_onehot,
  output logic [clog2_min1(N)-1:0]  grant_idx
);

  localparam int IW = clog2_min1(N);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    found        = 1'b0;
    cand         = '0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(rr_ptr_q) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) grant_onehot[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      if (grant_idx == IW'(N - 1)) rr_ptr_d = '0;
      else                         rr_ptr_d = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/bus_ram.sv
// Multi-channel system RAM: round-robin shared array, byte enables,
// range checking and a fixed-latency response pipeline.
module bus_ram
  import bus_ram_pkg::*;
#(
  parameter int ADDR_W   = 56,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 4096,
  parameter int CHANNELS = 2,
  parameter int LATENCY  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            req_valid,
  output logic [CHANNELS-1:0]            req_ready,
  input  logic [CHANNELS*ADDR_W-1:0]     req_addr,
  input  logic [CHANNELS-1:0]            req_we,
  input  logic [CHANNELS*DATA_W/8-1:0]   req_be,
  input  logic [CHANNELS*DATA_W-1:0]     req_wdata,
  output logic [CHANNELS-1:0]            rsp_valid,
  output logic [CHANNELS*DATA_W-1:0]     rsp_rdata,
  output logic [CHANNELS-1:0]            rsp_err
);

  localparam int BE_W  = DATA_W / BYTE_W;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = clog2_min1(DEPTH);
  localparam int CH_W  = clog2_min1(CHANNELS);

  typedef struct packed {
    logic              valid;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_stage_t;

  logic [CHANNELS-1:0] grant;
  logic [CH_W-1:0]     gidx;
  logic                accept;

  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_we;
  logic [BE_W-1:0]     sel_be;
  logic [DATA_W-1:0]   sel_wdata;
  logic [ADDR_W-1:0]   word_idx;
  logic [IDX_W-1:0]    widx;
  logic                oob;
  logic                wr_en;

  logic [DATA_W-1:0]   mem [DEPTH];

  rsp_stage_t          pipe_q [LATENCY];
  rsp_stage_t          pipe_d [LATENCY];
  rsp_stage_t          last;

  rr_arbiter #(.N(CHANNELS)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (req_valid),
    .advance      (accept),
    .grant_onehot (grant),
    .grant_idx    (gidx)
  );

  // Ready is forced low while reset is held.
  always_comb begin
    req_ready = rst ? grant : '0;
    accept    = |req_ready;
  end

  always_comb begin
    sel_addr  = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
    sel_we    = req_we[gidx];
    sel_be    = req_be[int'(gidx)*BE_W +: BE_W];
    sel_wdata = req_wdata[int'(gidx)*DATA_W +: DATA_W];
    word_idx  = sel_addr >> OFF_W;
    oob       = word_idx >= ADDR_W'(DEPTH);
    widx      = word_idx[IDX_W-1:0];
    wr_en     = accept && sel_we && !oob;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < BE_W; k++) begin
        if (sel_be[k])
          mem[widx][k*BYTE_W +: BYTE_W] <= sel_wdata[k*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    pipe_d[0].valid = accept;
    pipe_d[0].ch    = accept ? gidx : '0;
    pipe_d[0].err   = accept && oob;
    pipe_d[0].rdata = (accept && !sel_we && !oob) ? mem[widx] : '0;
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  always_comb begin
    last      = pipe_q[LATENCY-1];
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = '0;
    if (last.valid) begin
      rsp_valid[last.ch]                     = 1'b1;
      rsp_err[last.ch]                       = last.err;
      rsp_rdata[int'(last.ch)*DATA_W +: DATA_W] = last.rdata;
    end
  end

endmodule

// File: tb/tb_bus_ram.sv
// Self-checking bench for bus_ram: LATENCY=1 and LATENCY=3 instances
// share stimulus and are checked against a behavioural memory model.
module tb_bus_ram;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   v;
  logic [111:0] addr;
  logic [1:0]   we;
  logic [15:0]  be;
  logic [127:0] wd;

  logic [1:0]   r1_ready, r1_valid, r1_err;
  logic [127:0] r1_rdata;
  logic [1:0]   r3_ready, r3_valid, r3_err;
  logic [127:0] r3_rdata;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_ram #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(v), .req_ready(r1_ready),
    .req_addr(addr), .req_we(we), .req_be(be), .req_wdata(wd),
    .rsp_valid(r1_valid), .rsp_rdata(r1_rdata), .rsp_err(r1_err)
  );

  bus_ram #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(v), .req_ready(r3_ready),
    .req_addr(addr), .req_we(we), .req_be(be), .req_wdata(wd),
    .rsp_valid(r3_valid), .rsp_rdata(r3_rdata), .rsp_err(r3_err)
  );

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: memory contents plus a list of responses due.
  typedef struct {
    int          due;
    int          ch;
    logic [63:0] d;
    logic        e;
  } exp_t;

  logic [63:0] mem_m [longint];
  exp_t        q1[$];
  exp_t        q3[$];
  int          rr;
  logic [63:0] last_d [2];
  logic        last_e [2];
  bit          lat_rec = 0;
  int          acc_cyc[$];
  int          r3_cyc[$];
  logic [63:0] r3_dat[$];

  function automatic logic [131:0] exp_vec(input exp_t q[$], input int c);
    logic [131:0] r;
    r = '0;
    foreach (q[i]) begin
      if (q[i].due == c) begin
        r[130 + q[i].ch]       = 1'b1;
        r[128 + q[i].ch]       = q[i].e;
        r[q[i].ch*64 +: 64]    = q[i].d;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    int          g;
    longint      idx;
    logic [55:0] a;
    logic [63:0] w;
    logic [63:0] rd;
    logic        e;
    exp_t        it;
    if (!rst) begin
      chk("reset_out1", {r1_ready, r1_valid, r1_err, r1_rdata}, '0);
      chk("reset_out3", {r3_ready, r3_valid, r3_err, r3_rdata}, '0);
      q1.delete();
      q3.delete();
      rr = 0;
    end else begin
      chk("rsp_l1", {r1_valid, r1_err, r1_rdata}, exp_vec(q1, cyc));
      chk("rsp_l3", {r3_valid, r3_err, r3_rdata}, exp_vec(q3, cyc));
      for (int i = q1.size() - 1; i >= 0; i--) if (q1[i].due <= cyc) q1.delete(i);
      for (int i = q3.size() - 1; i >= 0; i--) if (q3[i].due <= cyc) q3.delete(i);
      for (int ch = 0; ch < 2; ch++) begin
        if (r1_valid[ch]) begin
          last_d[ch] = r1_rdata[ch*64 +: 64];
          last_e[ch] = r1_err[ch];
        end
      end
      if (lat_rec && r3_valid[0]) begin
        r3_cyc.push_back(cyc);
        r3_dat.push_back(r3_rdata[63:0]);
      end
      g = -1;
      for (int k = 0; k < 2; k++) begin
        if (g < 0 && v[(rr + k) % 2]) g = (rr + k) % 2;
      end
      chk("ready_l1", r1_ready, (g >= 0) ? (2'b01 << g) : 2'b00);
      chk("ready_l3", r3_ready, (g >= 0) ? (2'b01 << g) : 2'b00);
      if (g >= 0) begin
        a   = addr[g*56 +: 56];
        idx = longint'(a >> 3);
        e   = idx >= 4096;
        w   = mem_m.exists(idx) ? mem_m[idx] : 64'h0;
        rd  = 64'h0;
        if (we[g] && !e) begin
          for (int b = 0; b < 8; b++)
            if (be[g*8 + b]) w[b*8 +: 8] = wd[g*64 + b*8 +: 8];
          mem_m[idx] = w;
        end else if (!we[g] && !e) begin
          rd = w;
        end
        it.ch = g; it.d = rd; it.e = e;
        it.due = cyc + 1; q1.push_back(it);
        it.due = cyc + 3; q3.push_back(it);
        rr = (g + 1) % 2;
        if (lat_rec) acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input int ch, input logic w, input logic [55:0] a,
                     input logic [7:0] b, input logic [63:0] d);
    bit got;
    got = 0;
    addr[ch*56 +: 56] = a;
    we[ch]            = w;
    be[ch*8 +: 8]     = b;
    wd[ch*64 +: 64]   = d;
    v[ch]             = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = r1_ready[ch];
    end
    @(posedge clk);
    #1;
    v[ch] = 1'b0;
    chk("req_accept", got, 1);
  endtask

  task automatic rd_last(input int ch, input logic [55:0] a,
                         output logic [63:0] d, output logic e);
    idle(2);
    last_d[ch] = '1;
    last_e[ch] = 1'bx;
    req(ch, 1'b0, a, 8'h00, 64'h0);
    idle(3);
    d = last_d[ch];
    e = last_e[ch];
  endtask

  logic [63:0] d;
  logic        e;
  logic [1:0]  gseq [4];

  initial begin
    rst = 1'b1; v = '0; addr = '0; we = '0; be = '0; wd = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {r1_ready, r1_valid, r1_err, r1_rdata}, '0);
    @(posedge clk);
    #1 rst = 1'b1;

    req(0, 1'b1, 56'h10, 8'hFF, 64'hDEAD_BEEF_0123_4567);
    rd_last(0, 56'h10, d, e);
    chk("wr_rd_data", d, 64'hDEAD_BEEF_0123_4567);
    chk("wr_rd_err", e, 0);

    req(1, 1'b1, 56'h20, 8'hFF, 64'h0);
    req(1, 1'b1, 56'h20, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_last(1, 56'h20, d, e);
    chk("byte_en_data", d, 64'h0000_0000_FFFF_FFFF);

    idle(2);
    addr[55:0]   = 56'h10;
    addr[111:56] = 56'h20;
    we = 2'b00;
    v  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      gseq[k] = r1_ready;
      @(posedge clk);
      #1;
    end
    v = 2'b00;
    chk("rr_grant0", gseq[0], 2'b01);
    chk("rr_grant1", gseq[1], 2'b10);
    chk("rr_grant2", gseq[2], 2'b01);
    chk("rr_grant3", gseq[3], 2'b10);

    req(0, 1'b1, 56'h0, 8'hFF, 64'h1111_2222_3333_4444);
    rd_last(0, 56'h8000, d, e);
    chk("oob_err", e, 1);
    chk("oob_rdata", d, 64'h0);
    req(0, 1'b1, 56'h8000, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0);
    req(0, 1'b1, 56'h7FF8, 8'hFF, 64'hCAFE_F00D_1234_5678);
    rd_last(0, 56'h0, d, e);
    chk("oob_no_write", d, 64'h1111_2222_3333_4444);
    rd_last(0, 56'h7FFF, d, e);
    chk("last_word_data", d, 64'hCAFE_F00D_1234_5678);
    chk("last_word_err", e, 0);
    rd_last(1, 56'h1_0000_0000_0000, d, e);
    chk("oob_high_err", e, 1);

    idle(2);
    lat_rec = 1;
    req(0, 1'b0, 56'h10, 8'h00, 64'h0);
    req(0, 1'b0, 56'h20, 8'h00, 64'h0);
    req(0, 1'b0, 56'h7FF8, 8'h00, 64'h0);
    idle(8);
    lat_rec = 0;
    chk("lat_accepts", acc_cyc.size(), 3);
    chk("lat_rsps", r3_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("lat_cycle", (r3_cyc.size() > i && acc_cyc.size() > 0) ?
          r3_cyc[i] - acc_cyc[0] : -1, 3 + i);
    end
    chk("lat_data0", (r3_dat.size() > 0) ? r3_dat[0] : '1, 64'hDEAD_BEEF_0123_4567);
    chk("lat_data1", (r3_dat.size() > 1) ? r3_dat[1] : '1, 64'h0000_0000_FFFF_FFFF);
    chk("lat_data2", (r3_dat.size() > 2) ? r3_dat[2] : '1, 64'hCAFE_F00D_1234_5678);

    req(0, 1'b0, 56'h10, 8'h00, 64'h0);
    req(0, 1'b0, 56'h20, 8'h00, 64'h0);
    rst = 1'b0;
    #1;
    chk("rst_async_ctl", {r1_ready, r1_valid, r1_err, r3_ready, r3_valid, r3_err}, '0);
    chk("rst_async_d1", r1_rdata, '0);
    chk("rst_async_d3", r3_rdata, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(6);
    rd_last(0, 56'h10, d, e);
    chk("persist_after_rst", d, 64'hDEAD_BEEF_0123_4567);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
